// File: rtl/arm_mc_ctrl_pkg.sv
// Shared definitions for the ARM multicycle controller: FSM states and
// instruction field, ALU, extender and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXR    = 4'd6,
        EXI    = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_mc_ctrl_cond_check.sv
// Combinational ARM condition evaluation: cond field against NZCV flags.
// Condition 1111 is treated as never.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = i_flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = ~w_ge;
            COND_GT: o_cond_ex = ~w_z & w_ge;
            COND_LE: o_cond_ex = w_z | ~w_ge;
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM controller: FSM sequencing, datapath selects and NZCV flags.
// Define CTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module arm_mc_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        adr_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [1:0]  alu_control,
    output logic [3:0]  flags
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic       w_cond_ok;
    logic       w_mem_ok;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic [3:0] w_rd;
    logic       w_is_cmp;
    logic       w_rd_pc;
    logic [1:0] w_ex_alu;
    logic       w_logic_op;
    logic       w_flag_we;
    logic       w_unused;

    assign w_op     = ir[27:26];
    assign w_funct  = ir[25:20];
    assign w_cmd    = w_funct[4:1];
    assign w_rd     = ir[15:12];
    assign w_is_cmp = (w_cmd == CMD_CMP);
    assign w_rd_pc  = (w_rd == 4'hF);
    assign w_unused = ^{ir[19:16], ir[11:0], mem_ready};

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    arm_cond_check u_cond (
        .i_cond    (ir[31:28]),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ok)
    );

    always_comb begin
        case (w_cmd)
            CMD_ADD:          w_ex_alu = ALU_ADD;
            CMD_SUB, CMD_CMP: w_ex_alu = ALU_SUB;
            CMD_AND:          w_ex_alu = ALU_AND;
            CMD_ORR:          w_ex_alu = ALU_ORR;
            default:          w_ex_alu = ALU_ADD;
        endcase
    end

    // Logical ops only define N and Z; C and V carry over from the last arithmetic op.
    assign w_logic_op = (w_ex_alu == ALU_AND) || (w_ex_alu == ALU_ORR);
    assign w_flag_we  = ((r_state == EXR) || (r_state == EXI)) && r_cond_ex &&
                        (w_funct[0] || w_is_cmp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= state_t'(RST_STATE);
            r_flags   <= '0;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE)
                r_cond_ex <= w_cond_ok;
            if (w_flag_we)
                r_flags <= w_logic_op ? {alu_flags[3:2], r_flags[1:0]} : alu_flags;
        end
    end

    assign flags = r_flags;

    // Outputs are forced idle while reset is held so an aborted access has no side effects.
    always_comb begin
        w_next      = r_state;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = IMM_8;
        reg_src     = 2'b00;
        alu_control = ALU_ADD;
        if (reset_n) begin
            case (r_state)
                FETCH: begin
                    ir_write   = w_mem_ok;
                    pc_write   = w_mem_ok;
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (w_mem_ok)
                        w_next = DECODE;
                end
                DECODE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    imm_src   = w_op;
                    w_next    = FETCH;
                    if (w_cond_ok) begin
                        case (w_op)
                            OP_MEM:  w_next = MEMADR;
                            OP_BR:   w_next = BRANCH;
                            OP_DP:   w_next = w_funct[5] ? EXI : EXR;
                            default: w_next = FETCH;
                        endcase
                    end
                end
                MEMADR: begin
                    alu_src_b   = 2'b01;
                    imm_src     = IMM_12;
                    alu_control = w_funct[3] ? ALU_ADD : ALU_SUB;
                    w_next      = w_funct[0] ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    adr_src = 1'b1;
                    if (w_mem_ok)
                        w_next = MEMWB;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = r_cond_ex;
                    pc_write   = r_cond_ex & w_rd_pc;
                    w_next     = FETCH;
                end
                MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = r_cond_ex;
                    reg_src   = 2'b10;
                    if (w_mem_ok)
                        w_next = FETCH;
                end
                EXR, EXI: begin
                    alu_src_b   = (r_state == EXI) ? 2'b01 : 2'b00;
                    imm_src     = IMM_8;
                    alu_control = w_ex_alu;
                    w_next      = w_is_cmp ? FETCH : ALUWB;
                end
                ALUWB: begin
                    result_src = 2'b00;
                    reg_write  = r_cond_ex;
                    pc_write   = r_cond_ex & w_rd_pc;
                    w_next     = FETCH;
                end
                BRANCH: begin
                    reg_src    = 2'b01;
                    alu_src_b  = 2'b01;
                    imm_src    = IMM_24;
                    result_src = 2'b10;
                    pc_write   = r_cond_ex;
                    w_next     = FETCH;
                end
                default: w_next = FETCH;
            endcase
        end
    end

endmodule
